// File: rtl/usb_tx_engine_if.sv
// Byte handshake between a packet source and the USB transmit engine.
// The source holds tx_valid for the whole packet and presents each byte on tx_data.
// tx_ready marks the single cycle in which the engine takes that byte.
interface usb_tx_engine_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/usb_tx_engine.sv
// USB low-level packet transmitter.
// Sends SYNC, then bit-stuffed and NRZI-encoded data bytes (LSB first), then an EOP.
// The EOP is SE0 followed by J. All line outputs are registered.
module usb_tx_engine #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_BITS    = 8,
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic           clk,
  input  logic           nRST,
  usb_tx_engine_if.slave tx_if,
  output logic           d_plus_out,
  output logic           d_minus_out,
  output logic           tx_1_rx_0
);

  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int IDX_MAX_A = (SYNC_BITS > 8) ? SYNC_BITS : 8;
  localparam int IDX_MAX   = (EOP_SE0_BITS > IDX_MAX_A) ? EOP_SE0_BITS : IDX_MAX_A;
  localparam int IDX_W     = $clog2(IDX_MAX);
  localparam int ONES_W    = $clog2(STUFF_LIMIT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  SYNC_LAST  = IDX_W'(SYNC_BITS - 1);
  localparam logic [IDX_W-1:0]  EOP_LAST   = IDX_W'(EOP_SE0_BITS - 1);
  localparam logic [IDX_W-1:0]  BYTE_LAST  = IDX_W'(7);
  localparam logic [ONES_W-1:0] ONES_LIMIT = ONES_W'(STUFF_LIMIT);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // position inside the current bit period
  logic [IDX_W-1:0]  idx_q, idx_d;      // bit index inside SYNC, byte or SE0 run
  logic [7:0]        shift_q, shift_d;  // byte being sent, current bit in [0]
  logic [ONES_W-1:0] ones_q, ones_d;    // consecutive 1s already on the line
  logic              lvl_q, lvl_d;      // NRZI level, 1 = J
  logic              dp_q, dp_d;
  logic              dm_q, dm_d;
  logic              txen_q, txen_d;
  logic              bnd_q, bnd_d;      // pending stuff bit closes a field

  logic              strobe;
  logic              cur_bit;
  logic [ONES_W-1:0] ones_next;
  logic              field_end;
  logic              send_bit;
  logic              next_bit;
  logic              ready_c;

  // Next-state logic: every decision is taken on the last clock of a bit period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    ones_d    = ones_q;
    lvl_d     = lvl_q;
    dp_d      = dp_q;
    dm_d      = dm_q;
    txen_d    = txen_q;
    bnd_d     = bnd_q;
    field_end = 1'b0;
    send_bit  = 1'b0;
    next_bit  = 1'b0;
    ready_c   = 1'b0;

    strobe = (state_q != IDLE) && (cnt_q == CNT_LAST);
    if (state_q != IDLE) begin
      cnt_d = strobe ? '0 : cnt_q + 1'b1;
    end

    // Bit currently on the line and the run length once it completes.
    case (state_q)
      SYNC:    cur_bit = (idx_q == SYNC_LAST);
      DATA:    cur_bit = shift_q[0];
      default: cur_bit = 1'b0;
    endcase
    if (cur_bit) begin
      ones_next = (ones_q == ONES_LIMIT) ? ones_q : ones_q + 1'b1;
    end else begin
      ones_next = '0;
    end

    case (state_q)
      IDLE: begin
        dp_d   = 1'b1;
        dm_d   = 1'b0;
        lvl_d  = 1'b1;
        txen_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        ones_d = '0;
        bnd_d  = 1'b0;
        if (tx_if.tx_valid) begin
          state_d  = SYNC;
          txen_d   = 1'b1;
          send_bit = 1'b1;
          next_bit = (SYNC_LAST == '0);
        end
      end
      SYNC: begin
        if (strobe) begin
          ones_d = ones_next;
          if (idx_q == SYNC_LAST) begin
            if (ones_next == ONES_LIMIT) begin
              state_d  = STUFF;
              bnd_d    = 1'b1;
              send_bit = 1'b1;
            end else begin
              field_end = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 1'b1;
            send_bit = 1'b1;
            next_bit = ((idx_q + 1'b1) == SYNC_LAST);
          end
        end
      end
      DATA: begin
        if (strobe) begin
          ones_d  = ones_next;
          shift_d = {1'b0, shift_q[7:1]};
          if (ones_next == ONES_LIMIT) begin
            state_d  = STUFF;
            bnd_d    = (idx_q == BYTE_LAST);
            idx_d    = idx_q + 1'b1;
            send_bit = 1'b1;
          end else if (idx_q == BYTE_LAST) begin
            field_end = 1'b1;
          end else begin
            idx_d    = idx_q + 1'b1;
            send_bit = 1'b1;
            next_bit = shift_q[1];
          end
        end
      end
      STUFF: begin
        if (strobe) begin
          ones_d = '0;
          if (bnd_q) begin
            field_end = 1'b1;
          end else begin
            state_d  = DATA;
            send_bit = 1'b1;
            next_bit = shift_q[0];
          end
        end
      end
      EOP_SE0: begin
        if (strobe) begin
          if (idx_q == EOP_LAST) begin
            state_d = EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
            lvl_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EOP_J: begin
        if (strobe) begin
          state_d = IDLE;
          txen_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // End of SYNC or of a byte: take the next byte, or close the packet.
    if (field_end) begin
      bnd_d = 1'b0;
      idx_d = '0;
      if (tx_if.tx_valid) begin
        ready_c  = 1'b1;
        shift_d  = tx_if.tx_data;
        state_d  = DATA;
        send_bit = 1'b1;
        next_bit = tx_if.tx_data[0];
      end else begin
        state_d = EOP_SE0;
        dp_d    = 1'b0;
        dm_d    = 1'b0;
      end
    end

    // NRZI: a 0 toggles the line, a 1 holds it.
    if (send_bit) begin
      lvl_d = next_bit ? lvl_q : ~lvl_q;
      dp_d  = lvl_d;
      dm_d  = ~lvl_d;
    end
  end

  // State and output registers with synchronous active-low reset to idle J.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ones_q  <= '0;
      lvl_q   <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      txen_q  <= 1'b0;
      bnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ones_q  <= ones_d;
      lvl_q   <= lvl_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      txen_q  <= txen_d;
      bnd_q   <= bnd_d;
    end
  end

  // tx_ready qualifies the source's tx_valid in the same cycle, so it stays combinational.
  assign tx_if.tx_ready = ready_c & nRST;
  assign d_plus_out     = dp_q;
  assign d_minus_out    = dm_q;
  assign tx_1_rx_0      = txen_q;

endmodule

// File: tb/tb_usb_tx_engine.sv
// Self-checking bench for usb_tx_engine.
// A protocol model pushes the expected per-cycle line state and ready cycles into queues.
// The sampled DUT output is popped and compared against them; the line is also decoded back into bytes.
module tb_usb_tx_engine;
  localparam int CPB    = 4;
  localparam int SB     = 8;
  localparam int LIM    = 6;
  localparam int EOPB   = 2;
  localparam int HS_CPB = 2;
  localparam int HS_SB  = 32;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  usb_tx_engine_if fs_if();
  usb_tx_engine_if hs_if();
  logic fs_dp, fs_dm, fs_en;
  logic hs_dp, hs_dm, hs_en;

  usb_tx_engine #(.CLKS_PER_BIT(CPB), .SYNC_BITS(SB), .STUFF_LIMIT(LIM), .EOP_SE0_BITS(EOPB)) u_fs (
    .clk(clk), .nRST(nRST), .tx_if(fs_if),
    .d_plus_out(fs_dp), .d_minus_out(fs_dm), .tx_1_rx_0(fs_en)
  );

  usb_tx_engine #(.CLKS_PER_BIT(HS_CPB), .SYNC_BITS(HS_SB), .STUFF_LIMIT(LIM), .EOP_SE0_BITS(EOPB)) u_hs (
    .clk(clk), .nRST(nRST), .tx_if(hs_if),
    .d_plus_out(hs_dp), .d_minus_out(hs_dm), .tx_1_rx_0(hs_en)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [2:0] exp_q[$];     // per cycle {tx_1_rx_0, d_plus, d_minus}
  int         rdy_q[$];     // expected tx_ready cycle numbers
  logic [7:0] byte_q[$];    // bytes expected back from the decoder
  logic [7:0] pkt_bytes[$];

  logic m_lvl;
  int   m_ones;
  int   m_nsym;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit hs, input logic v, input logic [7:0] d);
    if (hs) begin
      hs_if.tx_valid = v;
      hs_if.tx_data  = d;
    end else begin
      fs_if.tx_valid = v;
      fs_if.tx_data  = d;
    end
  endtask

  task automatic push_sym(input logic [1:0] sym, input int cpb);
    for (int k = 0; k < cpb; k++) exp_q.push_back({1'b1, sym});
    m_nsym++;
  endtask

  // One logical bit onto the wire: NRZI encode, then insert a stuffed 0 after LIM ones.
  task automatic emit_bit(input logic b, input int cpb);
    if (!b) m_lvl = ~m_lvl;
    push_sym({m_lvl, ~m_lvl}, cpb);
    if (b) begin
      m_ones++;
      if (m_ones == LIM) begin
        m_lvl = ~m_lvl;
        push_sym({m_lvl, ~m_lvl}, cpb);
        m_ones = 0;
      end
    end else begin
      m_ones = 0;
    end
  endtask

  task automatic build_expected(input int cpb, input int sb);
    exp_q.delete();
    rdy_q.delete();
    byte_q.delete();
    m_lvl  = 1'b1;
    m_ones = 0;
    m_nsym = 0;
    for (int i = 0; i < sb; i++) emit_bit(i == sb - 1, cpb);
    for (int b = 0; b < pkt_bytes.size(); b++) begin
      rdy_q.push_back(m_nsym * cpb);
      byte_q.push_back(pkt_bytes[b]);
      for (int i = 0; i < 8; i++) emit_bit(pkt_bytes[b][i], cpb);
    end
    for (int i = 0; i < EOPB; i++) push_sym(2'b00, cpb);
    push_sym(2'b10, cpb);
  endtask

  task automatic run_packet(input string name, input bit hs, input int cpb, input int sb);
    int         n;
    int         bi;
    bit         adv;
    int         nrdy;
    logic [2:0] obs;
    logic [2:0] e;
    logic       rdy;
    logic [1:0] syms[$];
    logic [1:0] prev;
    logic [7:0] cur;
    logic [7:0] got[$];
    int         ones;
    int         maxrun;
    int         nbit;
    int         nsync;
    bit         skip;
    bit         done;
    logic       b;
    int         nb;

    build_expected(cpb, sb);
    n    = exp_q.size();
    bi   = 0;
    adv  = 0;
    nrdy = 0;
    @(posedge clk); #1;
    drive(hs, 1'b1, pkt_bytes[0]);
    for (int cyc = 1; cyc <= n + 1; cyc++) begin
      @(posedge clk); #1;
      if (adv) begin
        bi++;
        if (bi < pkt_bytes.size()) drive(hs, 1'b1, pkt_bytes[bi]);
        else drive(hs, 1'b0, 8'h00);
        adv = 0;
      end
      #1;
      obs = hs ? {hs_en, hs_dp, hs_dm} : {fs_en, fs_dp, fs_dm};
      rdy = hs ? hs_if.tx_ready : fs_if.tx_ready;
      chk($sformatf("%s se1@%0d", name, cyc), {31'd0, obs[1] & obs[0]}, 32'd0);
      e = (cyc <= n) ? exp_q.pop_front() : 3'b010;
      chk($sformatf("%s line@%0d", name, cyc), {29'd0, obs}, {29'd0, e});
      if (cyc <= n && ((cyc - 1) % cpb) == 0) syms.push_back(obs[1:0]);
      if (rdy) begin
        nrdy++;
        chk($sformatf("%s rdy_cyc", name), cyc, (rdy_q.size() > 0) ? rdy_q.pop_front() : -1);
        adv = 1;
      end
    end
    chk($sformatf("%s rdy_missing", name), rdy_q.size(), 0);

    // Decode the observed line independently: NRZI, stuff removal, skip SYNC, gather bytes.
    prev   = 2'b10;
    ones   = 0;
    maxrun = 0;
    nbit   = 0;
    nsync  = 0;
    skip   = 0;
    done   = 0;
    cur    = 8'h00;
    for (int i = 0; i < syms.size(); i++) begin
      if (!done) begin
        if (syms[i] == 2'b00) begin
          done = 1;
        end else begin
          b    = (syms[i] == prev);
          prev = syms[i];
          if (skip) begin
            chk($sformatf("%s stuff_zero", name), {31'd0, b}, 32'd0);
            skip = 0;
            ones = 0;
          end else begin
            if (b) begin
              ones++;
              if (ones > maxrun) maxrun = ones;
              if (ones == LIM) skip = 1;
            end else begin
              ones = 0;
            end
            if (nsync < sb) begin
              nsync++;
            end else begin
              cur[nbit] = b;
              nbit++;
              if (nbit == 8) begin
                got.push_back(cur);
                nbit = 0;
              end
            end
          end
        end
      end
    end
    chk($sformatf("%s run_le_limit", name), {31'd0, maxrun <= LIM}, 32'd1);
    chk($sformatf("%s nbytes", name), got.size(), byte_q.size());
    nb = (got.size() < byte_q.size()) ? got.size() : byte_q.size();
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s byte%0d", name, i), {24'd0, got[i]}, {24'd0, byte_q[i]});
    end
    $display("pkt %s: %0d cycles, %0d ready pulses, %0d bytes decoded", name, n, nrdy, got.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    nRST = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst fs", {28'd0, fs_en, fs_dp, fs_dm, fs_if.tx_ready}, {28'd0, 4'b0100});
    chk("rst hs", {28'd0, hs_en, hs_dp, hs_dm, hs_if.tx_ready}, {28'd0, 4'b0100});
    nRST = 1'b1;
    repeat (2) @(posedge clk);

    pkt_bytes = '{8'h00};
    run_packet("fs_00", 0, CPB, SB);
    pkt_bytes = '{8'hFF};
    run_packet("fs_ff", 0, CPB, SB);
    pkt_bytes = '{8'hA5, 8'h3C};
    run_packet("fs_a5_3c", 0, CPB, SB);
    pkt_bytes = '{8'hFC, 8'h81};
    run_packet("fs_fc_81", 0, CPB, SB);
    pkt_bytes = '{8'hFC};
    run_packet("fs_fc", 0, CPB, SB);

    // Reset in the middle of a packet, with tx_valid still high.
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h5A);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #2;
    end
    nRST = 1'b0;
    @(posedge clk); #2;
    chk("midrst line", {29'd0, fs_en, fs_dp, fs_dm}, {29'd0, 3'b010});
    chk("midrst ready", {31'd0, fs_if.tx_ready}, 32'd0);
    drive(0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    nRST = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("postrst idle", {29'd0, fs_en, fs_dp, fs_dm}, {29'd0, 3'b010});
    $display("pkt midreset: reset at cycle 20, line back to idle J");
    pkt_bytes = '{8'h5A, 8'hC3};
    run_packet("fs_after_rst", 0, CPB, SB);

    pkt_bytes = '{8'h00};
    run_packet("hs_00", 1, HS_CPB, HS_SB);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
